// File: rtl/alu_mc.sv
// Multi-cycle RV-style ALU: single-cycle base ops, bit-serial multiply/divide.
// Three-state FSM (IDLE/BUSY/DONE) with a registered result held until taken.
module alu_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_in1,
  input  logic [XLEN-1:0] alu_in2,
  input  logic [4:0]      alu_op_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic            op_err,
  output logic [1:0]      fsm_state
);

  // Handshake: an operation is taken on a clock edge where in_valid && in_ready
  // (and no flush); a result leaves on an edge where out_valid && out_ready.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [SHW-1:0]  cnt;
  logic [2:0]      mop;
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] qr, opb;
  logic            neg_q, neg_r;

  logic            accept, legal, is_mop, a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag, basic_res;
  logic [SHW-1:0]  sh;
  logic [XLEN:0]   sum, shifted, diff, acc_n;
  logic [XLEN-1:0] qr_n, quo, rem_mag, rem, m_res;
  logic [2*XLEN-1:0] prod, prod_s;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign fsm_state = state;
  assign accept    = in_valid && in_ready && !flush;
  assign legal     = (alu_op_ctrl <= 5'd9) || (alu_op_ctrl >= 5'd16 && alu_op_ctrl <= 5'd23);
  assign is_mop    = alu_op_ctrl[4];
  assign sh        = alu_in2[SHW-1:0];

  always_comb begin
    basic_res = '0;
    case (alu_op_ctrl)
      5'd0: basic_res = alu_in1 + alu_in2;
      5'd1: basic_res = alu_in1 - alu_in2;
      5'd2: basic_res = alu_in1 << sh;
      5'd3: basic_res = {{(XLEN-1){1'b0}}, $signed(alu_in1) < $signed(alu_in2)};
      5'd4: basic_res = {{(XLEN-1){1'b0}}, alu_in1 < alu_in2};
      5'd5: basic_res = alu_in1 ^ alu_in2;
      5'd6: basic_res = alu_in1 >> sh;
      5'd7: basic_res = $unsigned($signed(alu_in1) >>> sh);
      5'd8: basic_res = alu_in1 | alu_in2;
      5'd9: basic_res = alu_in1 & alu_in2;
      default: basic_res = '0;
    endcase
  end

  // Signed variants run on magnitudes; the sign is reapplied on the last iteration.
  always_comb begin
    a_sgn = alu_in1[XLEN-1] && (alu_op_ctrl == 5'd17 || alu_op_ctrl == 5'd18 ||
                                alu_op_ctrl == 5'd20 || alu_op_ctrl == 5'd22);
    b_sgn = alu_in2[XLEN-1] && (alu_op_ctrl == 5'd17 || alu_op_ctrl == 5'd20 ||
                                alu_op_ctrl == 5'd22);
    a_mag = a_sgn ? -alu_in1 : alu_in1;
    b_mag = b_sgn ? -alu_in2 : alu_in2;
  end

  always_comb begin
    sum     = {1'b0, acc[XLEN-1:0]} + (qr[0] ? {1'b0, opb} : '0);
    shifted = {acc[XLEN-1:0], qr[XLEN-1]};
    diff    = shifted - {1'b0, opb};
    acc_n   = {1'b0, sum[XLEN:1]};
    qr_n    = {sum[0], qr[XLEN-1:1]};
    if (mop[2]) begin
      if (shifted >= {1'b0, opb}) begin
        acc_n = diff;
        qr_n  = {qr[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shifted;
        qr_n  = {qr[XLEN-2:0], 1'b0};
      end
    end
    prod    = {acc_n[XLEN-1:0], qr_n};
    prod_s  = neg_q ? -prod : prod;
    quo     = neg_q ? -qr_n : qr_n;
    rem_mag = acc_n[XLEN-1:0];
    rem     = neg_r ? -rem_mag : rem_mag;
    case (mop)
      3'd0:                m_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    m_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          m_res = quo;
      default:             m_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mop     <= '0;
      acc     <= '0;
      qr      <= '0;
      opb     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      alu_out <= '0;
      zero    <= 1'b1;
      op_err  <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      cnt     <= '0;
      alu_out <= '0;
      zero    <= 1'b1;
      op_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (legal && is_mop) begin
            state <= BUSY;
            cnt   <= '0;
            mop   <= alu_op_ctrl[2:0];
            acc   <= '0;
            qr    <= alu_op_ctrl[2] ? a_mag : b_mag;
            opb   <= alu_op_ctrl[2] ? b_mag : a_mag;
            // A zero divisor must yield all ones, so never negate that quotient.
            neg_q <= (a_sgn ^ b_sgn) && !(alu_op_ctrl[2] && alu_in2 == '0);
            neg_r <= a_sgn;
          end else begin
            state   <= DONE;
            alu_out <= legal ? basic_res : '0;
            zero    <= legal ? (basic_res == '0) : 1'b1;
            op_err  <= !legal;
          end
        end
        BUSY: begin
          acc <= acc_n;
          qr  <= qr_n;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(XLEN-1)) begin
            state   <= DONE;
            alu_out <= m_res;
            zero    <= (m_res == '0);
            op_err  <= 1'b0;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
